mul_div_unit: RTL and testbench
===============================

# mul_div_unit

Multi-cycle multiply/divide unit living in the execute stage of the 5-stage MIPS pipeline; owns the architectural HI/LO registers. It executes MULT/MULTU in a single cycle and DIV/DIVU with an iterative 32-step divider. While a divide is in flight it raises `mdu_busy`, which drives the data hazard unit's `exe_busy` input and stalls the pipeline. MFHI/MFLO read `hi`/`lo` directly in the execute stage.

## Interface
Parameters:
- `DIV_ITERS`, 32, quotient bits produced (one per cycle); fixed at 32 for MIPS32.

Ports:
- `clk`  in  1  pipeline clock
- `resetn`  in  1  asynchronous, active-low reset
- `mdu_start`  in  1  one-cycle pulse from exe stage: valid MDU op this cycle
- `mdu_op`  in  3  op code (see `mdu_defs`), sampled when `mdu_start`=1
- `mdu_src_a`  in  32  rs value (dividend / multiplicand / MTHI/MTLO data)
- `mdu_src_b`  in  32  rt value (divisor / multiplier)
- `mdu_cancel`  in  1  exception flush: abort in-flight divide
- `mdu_busy`  out  1  divide in flight → hazard unit `exe_busy`
- `mdu_done`  out  1  one-cycle pulse: divide result written to HI/LO
- `hi`  out  32  HI register
- `lo`  out  32  LO register

## Operation
- Op codes: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6; 7 reserved, treated as NONE.
- `mdu_start` is a one-cycle pulse per instruction; the exe stage guarantees no re-pulse while the same instruction is held.
- Start accepted only in IDLE; ignored in any other state (no effect on HI/LO or state).
- MULT/MULTU: full 64-bit product of sign/zero-extended operands; {hi,lo} ← product at the accepting edge. No busy.
- MTHI/MTLO: hi (resp. lo) ← `mdu_src_a` at the accepting edge; other register unchanged.
- DIV/DIVU: latch |a|, |b| (magnitudes for DIV, raw for DIVU), quotient sign = sign(a)^sign(b), remainder sign = sign(a); enter RUN.
- State machine: IDLE → (div start) RUN → (counter = DIV_ITERS−1) FIX → IDLE.
  - RUN: one restoring-division step per cycle; 6-bit counter 0..31.
  - FIX: apply signs (two's-complement negate where required), write lo ← quotient, hi ← remainder, pulse `mdu_done`.
- `mdu_busy` = (state ≠ IDLE); combinational from state register.
- Divide by zero (either op): lo ← 0xFFFF_FFFF, hi ← `mdu_src_a`, same latency as normal divide, no sign fix.
- DIV 0x8000_0000 / 0xFFFF_FFFF: lo ← 0x8000_0000, hi ← 0 (natural magnitude result).
- `mdu_cancel` in RUN or FIX: next state IDLE, HI/LO unchanged, no `mdu_done`. Cancel in IDLE with simultaneous start: start is dropped.
- Reset (async, any state): state IDLE, counter 0, hi=0, lo=0, `mdu_busy`=0, `mdu_done`=0, divider datapath regs 0.

## Timing
- MULT/MULTU/MTHI/MTLO: result visible on `hi`/`lo` the cycle after `mdu_start`; a back-to-back MFHI in exe sees it without forwarding.
- DIV/DIVU: start in cycle 0 (busy=0); busy=1 in cycles 1..33 (32 RUN + 1 FIX); `mdu_done`=1 in cycle 33; hi/lo valid from cycle 34, busy=0.
- `mdu_done` and the HI/LO write occur on the same edge ending FIX.

## Structure
- Shared header/package `mdu_defs`: op-code constants, state encodings (IDLE/RUN/FIX), `DIV_ITERS`.
- One sub-module `div_core`: unsigned iterative restoring divider (dividend/divisor load, step enable, quotient/remainder outputs). Sign handling, multiplier, HI/LO and FSM stay in `mul_div_unit`.

## Test plan
- Reset mid-divide (assert `resetn`=0 in cycle 10) → immediately busy=0, hi=lo=0; next start behaves normally.
- MULT a=0xFFFF_FFFE (−2), b=3 → next cycle hi=0xFFFF_FFFF, lo=0xFFFF_FFFA; MULTU same operands → hi=0x0000_0002, lo=0xFFFF_FFFA; busy never 1.
- DIV a=−7, b=2 → busy 33 cycles, `mdu_done` in cycle 33, lo=0xFFFF_FFFD (−3), hi=0xFFFF_FFFF (−1); DIVU 100/7 → lo=14, hi=2.
- DIVU a=0x1234, b=0 → lo=0xFFFF_FFFF, hi=0x1234 after 34 cycles; DIV 0x8000_0000/−1 → lo=0x8000_0000, hi=0.
- Start DIV, assert `mdu_cancel` in cycle 20 → busy drops cycle 21, no `mdu_done`, hi/lo keep prior values; extra `mdu_start` pulses during busy ignored.
- MTHI 0xDEAD_BEEF then MTLO 0x1 on consecutive cycles → hi=0xDEAD_BEEF, lo=0x1, each visible the cycle after its start.

Source files
------------

// File: rtl/mul_div_unit_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, FSM state
// encodings, divider iteration count and a small sign helper.
package mdu_defs;

  localparam int DIV_ITERS = 32;

  // Op codes driven by the execute stage on mdu_op.
  localparam logic [2:0] OP_NONE  = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  // Divide sequencer states.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;

  // Two's-complement negate when en is set, pass-through otherwise.
  function automatic logic [31:0] neg_if(input logic [31:0] v, input logic en);
    return en ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/mul_div_unit_div_core.sv
// Unsigned iterative restoring divider: one quotient bit per step.
// The dividend is shifted out of the quotient register MSB-first while
// quotient bits are shifted in at the bottom.
module div_core (
  input  logic        clk,
  input  logic        resetn,
  input  logic        load,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  input  logic        step,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  logic [31:0] quo_q;
  logic [31:0] rem_q;
  logic [31:0] dvs_q;

  logic [32:0] partial;
  logic [32:0] diff;
  logic        fits;
  logic [31:0] rem_nxt;
  logic [31:0] quo_nxt;

  // One restoring step: bring down the next dividend bit and subtract if it fits.
  // NOTE: every signal written in always_comb is assigned on every path, so no latch is inferred.
  always_comb begin
    partial = {rem_q, quo_q[31]};
    diff    = partial - {1'b0, dvs_q};
    fits    = (partial >= {1'b0, dvs_q});
    rem_nxt = fits ? diff[31:0] : partial[31:0];
    quo_nxt = {quo_q[30:0], fits};
  end

  // Operand load on divide start, otherwise advance one step when enabled.
  // NOTE: the datapath registers are reset too, so the divider never exposes X after reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
    end else if (load) begin
      quo_q <= dividend;
      rem_q <= '0;
      dvs_q <= divisor;
    end else if (step) begin
      quo_q <= quo_nxt;
      rem_q <= rem_nxt;
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/mul_div_unit.sv
// MIPS multiply/divide unit owning HI/LO. Multiplies and MTHI/MTLO finish
// at the accepting edge; divides run a 32-step unsigned divider followed by
// one sign-fix cycle, holding mdu_busy high so the pipeline stalls.
module mul_div_unit
  import mdu_defs::*;
#(
  parameter int DIV_ITERS = mdu_defs::DIV_ITERS
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mdu_start,
  input  logic [2:0]  mdu_op,
  input  logic [31:0] mdu_src_a,
  input  logic [31:0] mdu_src_b,
  input  logic        mdu_cancel,
  output logic        mdu_busy,
  output logic        mdu_done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [5:0] LAST_STEP = 6'(DIV_ITERS - 1);

  logic [1:0]  state_q;
  logic [5:0]  cnt_q;
  logic        q_neg_q;
  logic        r_neg_q;
  logic        div0_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;

  logic        is_idle;
  logic        accept;
  logic        op_div;
  logic        op_divu;
  logic        div_load;
  logic        div_step;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic [31:0] lo_fix;
  logic [31:0] hi_fix;
  logic [63:0] mul_a;
  logic [63:0] mul_b;
  logic [63:0] product;

  assign is_idle  = (state_q == ST_IDLE);
  assign accept   = mdu_start & ~mdu_cancel & is_idle;
  assign op_div   = (mdu_op == OP_DIV);
  assign op_divu  = (mdu_op == OP_DIVU);
  assign div_load = accept & (op_div | op_divu);
  assign div_step = (state_q == ST_RUN) & ~mdu_cancel;

  // Signed divide works on magnitudes; signs are restored in FIX.
  assign mag_a = neg_if(mdu_src_a, op_div & mdu_src_a[31]);
  assign mag_b = neg_if(mdu_src_b, op_div & mdu_src_b[31]);

  // One 64-bit multiplier serves both MULT and MULTU; only the extension differs.
  assign mul_a   = {{32{(mdu_op == OP_MULT) & mdu_src_a[31]}}, mdu_src_a};
  assign mul_b   = {{32{(mdu_op == OP_MULT) & mdu_src_b[31]}}, mdu_src_b};
  assign product = mul_a * mul_b;

  div_core u_div_core (
    .clk       (clk),
    .resetn    (resetn),
    .load      (div_load),
    .dividend  (mag_a),
    .divisor   (mag_b),
    .step      (div_step),
    .quotient  (quotient),
    .remainder (remainder)
  );

  // Sign fix-up of the divider result. With a zero divisor the core leaves
  // |a| in the remainder, so restoring the dividend sign yields src_a exactly.
  always_comb begin
    lo_fix = neg_if(quotient, q_neg_q);
    hi_fix = neg_if(remainder, r_neg_q);
    if (div0_q) begin
      lo_fix = 32'hFFFF_FFFF;
    end
  end

  // Divide sequencer plus architectural HI/LO updates.
  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      div0_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            case (mdu_op)
              OP_MULT, OP_MULTU: begin
                hi_q <= product[63:32];
                lo_q <= product[31:0];
              end
              OP_MTHI: hi_q <= mdu_src_a;
              OP_MTLO: lo_q <= mdu_src_a;
              OP_DIV, OP_DIVU: begin
                q_neg_q <= op_div & (mdu_src_a[31] ^ mdu_src_b[31]);
                r_neg_q <= op_div & mdu_src_a[31];
                div0_q  <= (mdu_src_b == 32'd0);
                cnt_q   <= '0;
                state_q <= ST_RUN;
              end
              default: ;
            endcase
          end
        end
        ST_RUN: begin
          if (mdu_cancel) begin
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + 6'd1;
            if (cnt_q == LAST_STEP) begin
              state_q <= ST_FIX;
            end
          end
        end
        ST_FIX: begin
          if (!mdu_cancel) begin
            hi_q <= hi_fix;
            lo_q <= lo_fix;
          end
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign mdu_busy = ~is_idle;
  assign mdu_done = (state_q == ST_FIX) & ~mdu_cancel;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: a cycle-level reference model in the
// stimulus pushes expected HI/LO results into a scoreboard queue; a monitor
// on the falling edge pops and compares them, and checks busy every cycle.
module tb_mul_div_unit;

  localparam logic [2:0] T_NONE  = 3'd0;
  localparam logic [2:0] T_MULT  = 3'd1;
  localparam logic [2:0] T_MULTU = 3'd2;
  localparam logic [2:0] T_DIV   = 3'd3;
  localparam logic [2:0] T_DIVU  = 3'd4;
  localparam logic [2:0] T_MTHI  = 3'd5;
  localparam logic [2:0] T_MTLO  = 3'd6;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        mdu_start = 1'b0;
  logic [2:0]  mdu_op = 3'd0;
  logic [31:0] mdu_src_a = '0;
  logic [31:0] mdu_src_b = '0;
  logic        mdu_cancel = 1'b0;
  logic        mdu_busy;
  logic        mdu_done;
  logic [31:0] hi;
  logic [31:0] lo;

  mul_div_unit dut (
    .clk        (clk),
    .resetn     (resetn),
    .mdu_start  (mdu_start),
    .mdu_op     (mdu_op),
    .mdu_src_a  (mdu_src_a),
    .mdu_src_b  (mdu_src_b),
    .mdu_cancel (mdu_cancel),
    .mdu_busy   (mdu_busy),
    .mdu_done   (mdu_done),
    .hi         (hi),
    .lo         (lo)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Scoreboard entry: an immediate result due in a given cycle, or a divide
  // whose done pulse is due in a given cycle (results visible one cycle later).
  typedef struct {
    bit          is_div;
    int          due;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t sb_q[$];

  // Reference model state.
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  int          busy_start = -1;
  int          busy_end = -1;
  bit          pend_valid = 0;
  int          pend_done = 0;
  logic [31:0] pend_hi, pend_lo;

  function automatic bit exp_busy(input int c);
    return (c > busy_start) && (c <= busy_end);
  endfunction

  // Drive one cycle of inputs and update the reference model accordingly.
  task automatic drive(input logic st, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic cn);
    int c;
    bit busy_now;
    exp_t e;
    longint          ps;
    longint unsigned pu;
    int sa, sb;
    c = cyc;
    if (pend_valid && c > pend_done) begin
      m_hi = pend_hi;
      m_lo = pend_lo;
      pend_valid = 0;
    end
    busy_now = exp_busy(c);
    mdu_start = st; mdu_op = op; mdu_src_a = a; mdu_src_b = b; mdu_cancel = cn;
    if (busy_now && cn) begin
      busy_end = c;
      if (pend_valid) begin
        pend_valid = 0;
        void'(sb_q.pop_back());
      end
    end else if (!busy_now && st && !cn) begin
      e.is_div = 0; e.due = c + 1;
      case (op)
        T_MULT: begin
          ps = longint'($signed(a)) * longint'($signed(b));
          m_hi = ps[63:32]; m_lo = ps[31:0];
          e.hi = m_hi; e.lo = m_lo; sb_q.push_back(e);
        end
        T_MULTU: begin
          pu = 64'(a) * 64'(b);
          m_hi = pu[63:32]; m_lo = pu[31:0];
          e.hi = m_hi; e.lo = m_lo; sb_q.push_back(e);
        end
        T_MTHI: begin
          m_hi = a; e.hi = m_hi; e.lo = m_lo; sb_q.push_back(e);
        end
        T_MTLO: begin
          m_lo = a; e.hi = m_hi; e.lo = m_lo; sb_q.push_back(e);
        end
        T_DIV, T_DIVU: begin
          if (b == 32'd0) begin
            pend_lo = 32'hFFFF_FFFF; pend_hi = a;
          end else if (op == T_DIVU) begin
            pend_lo = a / b; pend_hi = a % b;
          end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            pend_lo = 32'h8000_0000; pend_hi = 32'd0;
          end else begin
            sa = $signed(a); sb = $signed(b);
            pend_lo = sa / sb; pend_hi = sa % sb;
          end
          pend_valid = 1;
          pend_done = c + 33;
          busy_start = c;
          busy_end = c + 33;
          e.is_div = 1; e.due = c + 33; e.hi = pend_hi; e.lo = pend_lo;
          sb_q.push_back(e);
        end
        default: ;
      endcase
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, T_NONE, '0, '0, 1'b0);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear immediately.
  task automatic do_reset();
    mdu_start = 0; mdu_cancel = 0;
    resetn = 0;
    sb_q.delete();
    pend_valid = 0;
    busy_start = -1; busy_end = -1;
    m_hi = '0; m_lo = '0;
    #1;
    check("reset_busy", 32'(mdu_busy), 32'd0);
    check("reset_done", 32'(mdu_done), 32'd0);
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);
    @(posedge clk); #1;
    resetn = 1;
    @(posedge clk); #1;
  endtask

  // Divide followed by a window of ignored start pulses and optional cancel.
  task automatic div_with_noise(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                input int cancel_at, input bit noise);
    logic ns;
    drive(1'b1, op, a, b, 1'b0);
    for (int k = 1; k <= 34; k++) begin
      ns = noise && (k <= 33) && (cancel_at == 0 || k <= cancel_at) && ($urandom_range(0, 2) == 0);
      drive(ns, 3'($urandom_range(0, 7)), $urandom, $urandom, 1'(k == cancel_at));
    end
  endtask

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 6))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      4: return -32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  // Monitor: busy every cycle, done timing and HI/LO against the scoreboard.
  bit   hl_wait = 0;
  int   hl_cyc = 0;
  exp_t hl_exp;
  always @(negedge clk) begin
    exp_t e;
    if (!resetn) begin
      hl_wait = 0;
    end else begin
      check("busy", 32'(mdu_busy), 32'(exp_busy(cyc)));
      if (hl_wait && cyc == hl_cyc) begin
        check("div_hi", hi, hl_exp.hi);
        check("div_lo", lo, hl_exp.lo);
        hl_wait = 0;
      end
      if (mdu_done) begin
        if (sb_q.size() > 0 && sb_q[0].is_div) begin
          e = sb_q.pop_front();
          check("done_cycle", 32'(cyc), 32'(e.due));
          hl_wait = 1; hl_cyc = cyc + 1; hl_exp = e;
        end else begin
          errors++; checks++;
          $display("FAIL unexpected_done @cycle %0d: got 1 expected 0", cyc);
        end
      end
      while (sb_q.size() > 0 && !sb_q[0].is_div && sb_q[0].due <= cyc) begin
        e = sb_q.pop_front();
        check("imm_hi", hi, e.hi);
        check("imm_lo", lo, e.lo);
      end
      if (sb_q.size() > 0 && sb_q[0].is_div && cyc > sb_q[0].due) begin
        e = sb_q.pop_front();
        errors++; checks++;
        $display("FAIL missing_done @cycle %0d: got no pulse expected pulse at %0d", cyc, e.due);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    #12;
    check("init_busy", 32'(mdu_busy), 32'd0);
    check("init_hi", hi, 32'd0);
    check("init_lo", lo, 32'd0);
    @(posedge clk); #1;
    resetn = 1;
    @(posedge clk); #1;
    idle(2);

    // Reset in cycle 10 of a divide, then a normal divide afterwards.
    drive(1'b1, T_DIV, 32'd1000, 32'd3, 1'b0);
    idle(9);
    do_reset();
    div_with_noise(T_DIVU, 32'd100, 32'd7, 0, 0);

    // Multiplies with a negative operand, signed then unsigned.
    drive(1'b1, T_MULT, 32'hFFFF_FFFE, 32'd3, 1'b0);
    drive(1'b1, T_MULTU, 32'hFFFF_FFFE, 32'd3, 1'b0);
    idle(1);
    check("multu_hi_direct", hi, 32'h0000_0002);
    check("multu_lo_direct", lo, 32'hFFFF_FFFA);

    // Signed divide with negative dividend, divide by zero, overflow case.
    div_with_noise(T_DIV, -32'd7, 32'd2, 0, 0);
    check("div_lo_direct", lo, 32'hFFFF_FFFD);
    check("div_hi_direct", hi, 32'hFFFF_FFFF);
    div_with_noise(T_DIVU, 32'h1234, 32'd0, 0, 0);
    div_with_noise(T_DIV, 32'hFFFF_FFF0, 32'd0, 0, 0);
    div_with_noise(T_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);

    // Cancel in cycle 20 with ignored start pulses; cancel in the FIX cycle.
    div_with_noise(T_DIV, 32'd12345, 32'd67, 20, 1);
    div_with_noise(T_DIVU, 32'd999, 32'd10, 33, 1);
    // Start dropped when cancel coincides with it in IDLE.
    drive(1'b1, T_MULT, 32'd5, 32'd5, 1'b1);
    idle(2);

    // Back-to-back MTHI/MTLO.
    drive(1'b1, T_MTHI, 32'hDEAD_BEEF, '0, 1'b0);
    drive(1'b1, T_MTLO, 32'h0000_0001, '0, 1'b0);
    idle(1);
    check("mthi_direct", hi, 32'hDEAD_BEEF);
    check("mtlo_direct", lo, 32'h0000_0001);

    // Randomised mix.
    for (int i = 0; i < 150; i++) begin
      logic [2:0] op;
      op = 3'($urandom_range(0, 7));
      if (op == T_DIV || op == T_DIVU) begin
        div_with_noise(op, pick_val(), pick_val(),
                       ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 33)) : 0, 1);
      end else begin
        drive(1'b1, op, pick_val(), pick_val(), 1'($urandom_range(0, 7) == 0));
        if ($urandom_range(0, 1) == 0) idle(1);
      end
    end

    idle(40);
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
